sap_datapath: RTL and testbench

SAP-1 datapath: W bus, program counter, MAR, 16×8 RAM, instruction register, accumulator, B register, add/subtract ALU and output register. It executes the 12-bit control word produced each clock by the SAP-1 controller and returns the opcode nibble to it. It also exposes a RAM programming port, so a program can be loaded before the controller runs.

---
 rtl/sap_datapath.sv | 103 ++++++++++
 tb/tb_sap_datapath.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sap_datapath.sv
// rtl/sap_datapath.sv - SAP-1 datapath: W bus, PC, MAR, 16x8 RAM, IR, A, B, add/sub ALU, OUT.
module sap_datapath (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] control_word,
  input  logic        prog_en,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [3:0]  instruction,
  output logic [7:0]  out_value,
  output logic        carry,
  output logic [7:0]  w_bus,
  output logic        bus_conflict
);

  logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
  assign {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n} = control_word;

  logic [3:0] pc_q, pc_d;
  logic [3:0] mar_q, mar_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] out_q, out_d;
  logic       carry_q, carry_d;
  logic [7:0] ram_q [16];

  logic [8:0] alu_sum;
  logic [7:0] bus;
  logic [4:0] drivers;

  // Subtraction is A + ~B + 1, so bit 8 set means no borrow.
  always_comb begin
    alu_sum = {1'b0, a_q} + {1'b0, (su ? ~b_q : b_q)} + {8'd0, su};
  end

  always_comb begin
    drivers = {ep, ~ce_n, ~ei_n, ea, eu};
    bus     = 8'h00;
    if (ep)
      bus = {4'h0, pc_q};
    else if (!ce_n)
      bus = ram_q[mar_q];
    else if (!ei_n)
      bus = {4'h0, ir_q[3:0]};
    else if (ea)
      bus = a_q;
    else if (eu)
      bus = alu_sum[7:0];
  end

  always_comb begin
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    if (!prog_en) begin
      if (cp)    pc_d  = pc_q + 4'd1;
      if (!lm_n) mar_d = bus[3:0];
      if (!li_n) ir_d  = bus;
      if (!la_n) a_d   = bus;
      if (!lb_n) b_d   = bus;
      if (!lo_n) out_d = bus;
      if (!la_n && eu) carry_d = alu_sum[8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= 4'h0;
      mar_q   <= 4'h0;
      ir_q    <= 8'h00;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      out_q   <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  // RAM survives reset; a write requested during reset is dropped.
  always_ff @(posedge clock) begin
    if (!reset && prog_en)
      ram_q[prog_addr] <= prog_data;
  end

  assign w_bus        = bus;
  assign bus_conflict = (drivers & (drivers - 5'd1)) != 5'd0;
  assign instruction  = ir_q[7:4];
  assign out_value    = out_q;
  assign carry        = carry_q;

endmodule

// File: tb/tb_sap_datapath.sv
// tb/tb_sap_datapath.sv - table-driven directed bench for sap_datapath.
module tb_sap_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] control_word;
  logic        prog_en;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  instruction;
  logic [7:0]  out_value;
  logic        carry;
  logic [7:0]  w_bus;
  logic        bus_conflict;

  sap_datapath dut (
    .clock        (clock),
    .reset        (reset),
    .control_word (control_word),
    .prog_en      (prog_en),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .instruction  (instruction),
    .out_value    (out_value),
    .carry        (carry),
    .w_bus        (w_bus),
    .bus_conflict (bus_conflict)
  );

  always #5 clock = ~clock;

  // XOR with IDLE turns each named signal to its active level.
  localparam logic [11:0] IDLE = 12'b001111100011;
  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

  typedef struct {
    string       name;
    logic [11:0] act;
    logic        pe;
    logic [3:0]  pa;
    logic [7:0]  pd;
    logic [7:0]  bus;
    logic        conf;
    logic [3:0]  ins;
    logic [7:0]  outv;
    logic        c;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string name, logic [11:0] act, logic pe, logic [3:0] pa,
                              logic [7:0] pd, logic [7:0] bus, logic conf,
                              logic [3:0] ins, logic [7:0] outv, logic c);
    vec_t v;
    v.name = name; v.act = act; v.pe = pe; v.pa = pa; v.pd = pd;
    v.bus = bus; v.conf = conf; v.ins = ins; v.outv = outv; v.c = c;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
  task automatic step(string name, logic rst, logic [11:0] cw, logic pe, logic [3:0] pa,
                      logic [7:0] pd, logic chk_bus, logic [7:0] bus, logic conf,
                      logic chk_regs, logic [3:0] ins, logic [7:0] outv, logic c);
    reset = rst; control_word = cw; prog_en = pe; prog_addr = pa; prog_data = pd;
    #1;
    if (chk_bus) begin
      chk({name, ".bus"}, w_bus, bus);
      chk({name, ".conflict"}, {7'd0, bus_conflict}, {7'd0, conf});
    end
    if (chk_regs) begin
      chk({name, ".instruction"}, {4'd0, instruction}, {4'd0, ins});
      chk({name, ".out_value"}, out_value, outv);
      chk({name, ".carry"}, {7'd0, carry}, {7'd0, c});
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] paddr [8];
    logic [7:0] pdata [8];
    paddr = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB};
    pdata = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h10, 8'h14, 8'h18};
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("prog", 12'h0, 1'b1, paddr[i], pdata[i], 8'h00, 1'b0, 4'h0, 8'h00, 1'b0));

    vecs.push_back(mk("lda_t1",  EP|LM,    0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("lda_t2",  CP,       0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("lda_t3",  CE|LI,    0, 0, 0, 8'h09, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("lda_t4",  EI|LM,    0, 0, 0, 8'h09, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("lda_t5",  CE|LA,    0, 0, 0, 8'h10, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("lda_t6",  12'h0,    0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("lda_a",   EA,       0, 0, 0, 8'h10, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("add_t1",  EP|LM,    0, 0, 0, 8'h01, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("add_t2",  CP,       0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("add_t3",  CE|LI,    0, 0, 0, 8'h1A, 0, 4'h0, 8'h00, 0));
    vecs.push_back(mk("add_t4",  EI|LM,    0, 0, 0, 8'h0A, 0, 4'h1, 8'h00, 0));
    vecs.push_back(mk("add_t5",  CE|LB,    0, 0, 0, 8'h14, 0, 4'h1, 8'h00, 0));
    vecs.push_back(mk("add_t6",  LA|EU,    0, 0, 0, 8'h24, 0, 4'h1, 8'h00, 0));
    vecs.push_back(mk("add_a",   EA,       0, 0, 0, 8'h24, 0, 4'h1, 8'h00, 0));
    vecs.push_back(mk("sub_t1",  EP|LM,    0, 0, 0, 8'h02, 0, 4'h1, 8'h00, 0));
    vecs.push_back(mk("sub_t2",  CP,       0, 0, 0, 8'h00, 0, 4'h1, 8'h00, 0));
    vecs.push_back(mk("sub_t3",  CE|LI,    0, 0, 0, 8'h2B, 0, 4'h1, 8'h00, 0));
    vecs.push_back(mk("sub_t4",  EI|LM,    0, 0, 0, 8'h0B, 0, 4'h2, 8'h00, 0));
    vecs.push_back(mk("sub_t5",  CE|LB,    0, 0, 0, 8'h18, 0, 4'h2, 8'h00, 0));
    vecs.push_back(mk("sub_t6",  LA|EU|SU, 0, 0, 0, 8'h0C, 0, 4'h2, 8'h00, 0));
    vecs.push_back(mk("sub_a",   EA,       0, 0, 0, 8'h0C, 0, 4'h2, 8'h00, 1));
    vecs.push_back(mk("out_t1",  EP|LM,    0, 0, 0, 8'h03, 0, 4'h2, 8'h00, 1));
    vecs.push_back(mk("out_t2",  CP,       0, 0, 0, 8'h00, 0, 4'h2, 8'h00, 1));
    vecs.push_back(mk("out_t3",  CE|LI,    0, 0, 0, 8'hE0, 0, 4'h2, 8'h00, 1));
    vecs.push_back(mk("out_t4",  EA|LO,    0, 0, 0, 8'h0C, 0, 4'hE, 8'h00, 1));
    vecs.push_back(mk("out_t5",  12'h0,    0, 0, 0, 8'h00, 0, 4'hE, 8'h0C, 1));
    vecs.push_back(mk("ov_mar",  EP|LM,    0, 0, 0, 8'h04, 0, 4'hE, 8'h0C, 1));
    vecs.push_back(mk("ov_lda",  CE|LA,    0, 0, 0, 8'hF0, 0, 4'hE, 8'h0C, 1));
    vecs.push_back(mk("ov_prog", 12'h0,    1, 4, 8'h20, 8'h00, 0, 4'hE, 8'h0C, 1));
    vecs.push_back(mk("ov_ldb",  CE|LB,    0, 0, 0, 8'h20, 0, 4'hE, 8'h0C, 1));
    vecs.push_back(mk("ov_add",  LA|EU,    0, 0, 0, 8'h10, 0, 4'hE, 8'h0C, 1));
    vecs.push_back(mk("ov_a",    EA,       0, 0, 0, 8'h10, 0, 4'hE, 8'h0C, 1));
    vecs.push_back(mk("bw_sub",  LA|EU|SU, 0, 0, 0, 8'hF0, 0, 4'hE, 8'h0C, 1));
    vecs.push_back(mk("bw_a",    EA,       0, 0, 0, 8'hF0, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("c_hold",  EU,       0, 0, 0, 8'h10, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("c_held",  12'h0,    0, 0, 0, 8'h00, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("a_self",  EA|LA,    0, 0, 0, 8'hF0, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("a_kept",  EA,       0, 0, 0, 8'hF0, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("cf_ep_ea",    EP|EA,    0, 0, 0, 8'h04, 1, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("cf_ce_ei_eu", CE|EI|EU, 0, 0, 0, 8'h20, 1, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("cf_ei_ea",    EI|EA,    0, 0, 0, 8'h00, 1, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("cf_ea_eu",    EA|EU,    0, 0, 0, 8'hF0, 1, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("freeze", CE|LA|CP|LO|LI|LM|LB, 1, 5, 8'h77, 8'h20, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("frz_a",   EA,       0, 0, 0, 8'hF0, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("frz_pc",  EP,       0, 0, 0, 8'h04, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("frz_b",   EU,       0, 0, 0, 8'h10, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("to_pc5",  CP,       0, 0, 0, 8'h00, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("mar5",    EP|LM,    0, 0, 0, 8'h05, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("ram5",    CE,       0, 0, 0, 8'h77, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("ep_cp",   EP|CP,    0, 0, 0, 8'h05, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("pc6",     EP,       0, 0, 0, 8'h06, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("c_set",   LA|EU,    0, 0, 0, 8'h10, 0, 4'hE, 8'h0C, 0));
    vecs.push_back(mk("c_one",   12'h0,    0, 0, 0, 8'h00, 0, 4'hE, 8'h0C, 1));

    reset = 1'b1; control_word = IDLE; prog_en = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    @(posedge clock); @(posedge clock); #1;
    step("por", 1'b0, IDLE, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);

    foreach (vecs[i])
      step(vecs[i].name, 1'b0, IDLE ^ vecs[i].act, vecs[i].pe, vecs[i].pa, vecs[i].pd,
           1'b1, vecs[i].bus, vecs[i].conf, 1'b1, vecs[i].ins, vecs[i].outv, vecs[i].c);

    // Reset mid-program with an arbitrary word and a pending RAM write.
    step("rst", 1'b1, 12'($urandom), 1'b1, 4'h0, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    step("rst_idle", 1'b0, IDLE,      1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
    step("rst_a",    1'b0, IDLE ^ EA, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
    step("rst_pc",   1'b0, IDLE ^ EP, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
    step("rst_ir",   1'b0, IDLE ^ EI, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
    step("rst_b",    1'b0, IDLE ^ EU, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
    step("rst_ram0", 1'b0, IDLE ^ CE, 1'b0, 4'h0, 8'h00, 1'b1, 8'h09, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);

    // PC wrap: 17 increments from 0, then Ep+Cp together at PC=F.
    for (int i = 0; i < 17; i++)
      step("wrap_cp", 1'b0, IDLE ^ CP, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    step("wrap_pc1", 1'b0, IDLE ^ EP, 1'b0, 4'h0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
    for (int i = 0; i < 14; i++)
      step("wrap_cp", 1'b0, IDLE ^ CP, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    step("wrap_epcp", 1'b0, IDLE ^ (EP|CP), 1'b0, 4'h0, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
    step("wrap_pc0",  1'b0, IDLE ^ EP,      1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
